// File: rtl/ped_crossing_if.sv
// Signal bundle between the pedestrian-crossing FSM and its surroundings:
// the button, the 10-count timeout counter and the lamp drivers.
interface ped_crossing_if;
    logic       ped_req;
    logic       ten_timeout;
    logic       cnt_to_10;
    logic       car_green;
    logic       car_amber;
    logic       car_red;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
    logic [2:0] phase;

    modport master (
        output ped_req, ten_timeout,
        input  cnt_to_10, car_green, car_amber, car_red, walk, dont_walk,
               req_pending, phase
    );

    modport slave (
        input  ped_req, ten_timeout,
        output cnt_to_10, car_green, car_amber, car_red, walk, dont_walk,
               req_pending, phase
    );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian-crossing sequencer: drives the 10-count counter enable, counts
// whole timeout units per phase and serves one latched button request per crossing.
module ped_crossing_ctrl #(
    parameter int WALK_UNITS  = 3,
    parameter int FLASH_UNITS = 2
) (
    input logic          clk,
    input logic          rst,
    ped_crossing_if.slave bus
);

    localparam logic [2:0] GREEN_MIN  = 3'd0;
    localparam logic [2:0] GREEN_IDLE = 3'd1;
    localparam logic [2:0] AMBER      = 3'd2;
    localparam logic [2:0] ALL_RED    = 3'd3;
    localparam logic [2:0] WALK       = 3'd4;
    localparam logic [2:0] FLASH      = 3'd5;

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_UNITS - 1);
    localparam logic [3:0] FLASH_LOAD = 4'(FLASH_UNITS - 1);

    logic [2:0] r_state;
    logic [3:0] r_units;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_req_d;
    logic       r_req_pending;
    logic       r_blink;

    logic [2:0] w_next;
    logic [3:0] w_units_next;
    logic       w_timed;
    logic       w_tev;
    logic       w_last;
    logic       w_rise;
    logic       w_enter_walk;
    logic       w_enter_flash;
    logic       w_crossing;

    assign w_timed = (r_state == GREEN_MIN) || (r_state == AMBER) ||
                     (r_state == ALL_RED)   || (r_state == WALK)  ||
                     (r_state == FLASH);
    assign w_tev         = w_timed & bus.ten_timeout;
    assign w_last        = w_tev && (r_units == 4'd0);
    assign w_rise        = r_sync2 & ~r_req_d;
    assign w_crossing    = (r_state == WALK) || (r_state == FLASH);
    assign w_enter_walk  = (w_next == WALK)  && (r_state != WALK);
    assign w_enter_flash = (w_next == FLASH) && (r_state != FLASH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            GREEN_MIN:  if (w_last) w_next = r_req_pending ? AMBER : GREEN_IDLE;
            GREEN_IDLE: if (r_req_pending) w_next = AMBER;
            AMBER:      if (w_last) w_next = ALL_RED;
            ALL_RED:    if (w_last) w_next = WALK;
            WALK:       if (w_last) w_next = FLASH;
            FLASH:      if (w_last) w_next = GREEN_MIN;
            default:    w_next = ALL_RED;
        endcase
    end

    // Non-final timeouts only burn a unit; the state holds until the count is spent.
    always_comb begin
        w_units_next = r_units;
        if (w_enter_walk)
            w_units_next = WALK_LOAD;
        else if (w_enter_flash)
            w_units_next = FLASH_LOAD;
        else if (w_tev && (r_units != 4'd0))
            w_units_next = r_units - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= GREEN_MIN;
            r_units       <= 4'd0;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_req_d       <= 1'b0;
            r_req_pending <= 1'b0;
            r_blink       <= 1'b1;
        end else begin
            r_state <= w_next;
            r_units <= w_units_next;
            r_sync1 <= bus.ped_req;
            r_sync2 <= r_sync1;
            r_req_d <= r_sync2;
            if (w_enter_walk)
                r_req_pending <= 1'b0;
            else if (w_rise && !w_crossing)
                r_req_pending <= 1'b1;
            if (w_enter_flash)
                r_blink <= 1'b1;
            else if (r_state == FLASH)
                r_blink <= ~r_blink;
        end
    end

    // Enable is dropped in the timeout cycle so the counter clears its flag.
    assign bus.cnt_to_10   = w_timed & ~bus.ten_timeout;
    assign bus.req_pending = r_req_pending;
    assign bus.phase       = r_state;

    always_comb begin
        bus.car_green = 1'b0;
        bus.car_amber = 1'b0;
        bus.car_red   = 1'b0;
        bus.walk      = 1'b0;
        bus.dont_walk = 1'b0;
        case (r_state)
            GREEN_MIN, GREEN_IDLE: begin
                bus.car_green = 1'b1;
                bus.dont_walk = 1'b1;
            end
            AMBER: begin
                bus.car_amber = 1'b1;
                bus.dont_walk = 1'b1;
            end
            WALK: begin
                bus.car_red = 1'b1;
                bus.walk    = 1'b1;
            end
            FLASH: begin
                bus.car_red   = 1'b1;
                bus.dont_walk = r_blink;
            end
            default: begin
                bus.car_red   = 1'b1;
                bus.dont_walk = 1'b1;
            end
        endcase
    end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Pedestrian-crossing controller. It is the FSM that drives the enable input of the neighbouring 10-count timeout counter and consumes its timeout pulse.
- Sequences the car lights and pedestrian lights in whole timeout units.
- Latches a synchronised push-button request and enforces a minimum car-green time.
- Sits between the button/lamp I/O and the 10-count counter instance; both blocks share clk and rst.

Parameters:
- WALK_UNITS, 3: number of timeout units spent in WALK. Legal range 1..15.
- FLASH_UNITS, 2: number of timeout units spent in FLASH. Legal range 1..15.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-low reset.
- ped_req, input, 1: raw, asynchronous pedestrian push-button, active high.
- ten_timeout, input, 1: timeout flag from the 10-count counter.
- cnt_to_10, output, 1: count enable to the 10-count counter.
- car_green, output, 1: car green lamp.
- car_amber, output, 1: car amber lamp.
- car_red, output, 1: car red lamp.
- walk, output, 1: pedestrian walk lamp.
- dont_walk, output, 1: pedestrian don't-walk lamp.
- req_pending, output, 1: a latched pedestrian request is awaiting service.
- phase, output, 3: current state encoding.

Behaviour:
- States and phase encoding: GREEN_MIN=0, GREEN_IDLE=1, AMBER=2, ALL_RED=3, WALK=4, FLASH=5.
- Unused encodings 6 and 7 go to ALL_RED on the next edge (safe state).
- Timed states are GREEN_MIN, AMBER, ALL_RED, WALK and FLASH. GREEN_IDLE is untimed.
- cnt_to_10 is combinational: (state is timed) AND NOT ten_timeout.
  - Dropping the enable in the cycle the timeout is visible makes the counter clear its flag at the next edge, with its count held at 0.
  - This is the only input-to-output combinational path.
- Timeout event = timed state AND ten_timeout. In GREEN_IDLE, ten_timeout is ignored.
- One timeout unit = 11 clk cycles with the standard counter (10 enabled edges, then 1 cycle with the timeout visible).
- Unit counter (4 bit):
  - Loaded with WALK_UNITS-1 on entry to WALK and with FLASH_UNITS-1 on entry to FLASH.
  - On a timeout event with unit counter ≠ 0: decrement it, stay in the same state.
  - On a timeout event with unit counter = 0: take the transition.
- Transitions (all on timeout events except GREEN_IDLE):
  - GREEN_MIN → AMBER if req_pending is 1, otherwise → GREEN_IDLE.
  - GREEN_IDLE → AMBER on the first edge where req_pending is 1.
  - AMBER → ALL_RED.
  - ALL_RED → WALK.
  - WALK → FLASH.
  - FLASH → GREEN_MIN.
- Lamp decode (from the registered state, no extra latency):
  - GREEN_MIN, GREEN_IDLE: car_green=1, dont_walk=1.
  - AMBER: car_amber=1, dont_walk=1.
  - ALL_RED: car_red=1, dont_walk=1.
  - WALK: car_red=1, walk=1.
  - FLASH: car_red=1, walk=0, dont_walk = blink register.
    - Blink register is set to 1 on entry to FLASH and toggles every clk while in FLASH.
    - Outside FLASH, dont_walk follows the decode above.
  - All unlisted lamps are 0. Exactly one car lamp is high at any time.
- Request path:
  - ped_req passes through a 2-FF synchroniser, followed by a registered copy used for rising-edge detect.
  - A rising edge sets req_pending. ped_req sampled high at edge n gives req_pending=1 after edge n+2.
  - Edges detected while in WALK or FLASH are ignored.
  - req_pending is cleared on the edge that enters WALK; clear wins over a simultaneous set.
  - A button held high produces one request only.
- Reset (rst=0 at an edge) applies at any time, including mid-sequence:
  - state=GREEN_MIN; req_pending, synchroniser and edge registers, and unit counter all 0; blink register=1.
  - Resulting outputs: car_green=1, dont_walk=1, others 0, phase=0.
  - cnt_to_10=1 as soon as ten_timeout is 0; the counter shares the reset.

Test Plan:
- Reset, no request, real counter attached:
  - cnt_to_10=1 for 11 cycles.
  - GREEN_MIN→GREEN_IDLE at edge 11; cnt_to_10=0 thereafter.
  - Lamps stay green/dont_walk indefinitely.
- ped_req high for 5 cycles while in GREEN_IDLE:
  - req_pending=1 two edges after the first high sample; AMBER on the following edge.
  - AMBER 11 cycles, ALL_RED 11, WALK 33 (walk=1), FLASH 22 with dont_walk toggling 1,0,1,…, then GREEN_MIN.
  - req_pending=0 from WALK entry.
- Request at cycle 2 after reset: AMBER is not entered until the GREEN_MIN timeout; phase=2 on the edge after the 11th cycle.
- Press during WALK and during FLASH: req_pending stays 0; after FLASH, GREEN_MIN → GREEN_IDLE with no second crossing.
- ped_req held high through a whole crossing: exactly one crossing is served, ending in GREEN_IDLE.
- rst=0 for 1 cycle mid-WALK: next cycle phase=0, car_green=1, dont_walk=1, req_pending=0, cnt_to_10=1. Separately, ten_timeout forced to 1 in GREEN_IDLE causes no transition.
